id_ex_stage: RTL and testbench

Decode-to-execute pipeline register of the 5-stage RISC-V core, directly upstream of execute and the consumer of the hazard unit's forwarding selects. It captures decoded operands and control each cycle and presents the execute-stage source and destination registers back to the hazard unit. It resolves forwarded ALU operands with memory-stage-over-writeback priority. It also detects load-use hazards, stalling fetch/decode and inserting a bubble, and kills its contents on a branch flush.

---
 rtl/id_ex_if.sv | 69 ++++++
 rtl/id_ex_stage.sv | 98 +++++++++
 tb/tb_id_ex_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded operands and control in,
// registered execute slot, resolved operands and stall out.
interface id_ex_if #(
    parameter int XLEN = 32
);
    logic            i_ID_valid;
    logic [4:0]      i_ID_src_reg_1;
    logic [4:0]      i_ID_src_reg_2;
    logic [4:0]      i_ID_dst_reg;
    logic            i_ID_use_rs1;
    logic            i_ID_use_rs2;
    logic [XLEN-1:0] i_ID_rs1_data;
    logic [XLEN-1:0] i_ID_rs2_data;
    logic [XLEN-1:0] i_ID_imm;
    logic [XLEN-1:0] i_ID_pc;
    logic [3:0]      i_ID_alu_op;
    logic            i_ID_ctrl_alu_src;
    logic            i_ID_ctrl_reg_wr_en;
    logic            i_ID_ctrl_mem_rd;
    logic            i_ID_ctrl_mem_wr;
    logic            i_flush;
    logic            i_IM_forward_1;
    logic            i_IM_forward_2;
    logic            i_WB_forward_1;
    logic            i_WB_forward_2;
    logic [XLEN-1:0] i_IM_result;
    logic [XLEN-1:0] i_WB_result;

    logic            o_IE_valid;
    logic [4:0]      o_IE_src_reg_1;
    logic [4:0]      o_IE_src_reg_2;
    logic [4:0]      o_IE_dst_reg;
    logic [XLEN-1:0] o_IE_op_a;
    logic [XLEN-1:0] o_IE_op_b;
    logic [XLEN-1:0] o_IE_store_data;
    logic [XLEN-1:0] o_IE_imm;
    logic [XLEN-1:0] o_IE_pc;
    logic [3:0]      o_IE_alu_op;
    logic            o_IE_ctrl_reg_wr_en;
    logic            o_IE_ctrl_mem_rd;
    logic            o_IE_ctrl_mem_wr;
    logic            o_stall;

    modport master (
        output i_ID_valid, i_ID_src_reg_1, i_ID_src_reg_2, i_ID_dst_reg,
        output i_ID_use_rs1, i_ID_use_rs2, i_ID_rs1_data, i_ID_rs2_data,
        output i_ID_imm, i_ID_pc, i_ID_alu_op, i_ID_ctrl_alu_src,
        output i_ID_ctrl_reg_wr_en, i_ID_ctrl_mem_rd, i_ID_ctrl_mem_wr,
        output i_flush, i_IM_forward_1, i_IM_forward_2,
        output i_WB_forward_1, i_WB_forward_2, i_IM_result, i_WB_result,
        input  o_IE_valid, o_IE_src_reg_1, o_IE_src_reg_2, o_IE_dst_reg,
        input  o_IE_op_a, o_IE_op_b, o_IE_store_data, o_IE_imm, o_IE_pc,
        input  o_IE_alu_op, o_IE_ctrl_reg_wr_en, o_IE_ctrl_mem_rd,
        input  o_IE_ctrl_mem_wr, o_stall
    );

    modport slave (
        input  i_ID_valid, i_ID_src_reg_1, i_ID_src_reg_2, i_ID_dst_reg,
        input  i_ID_use_rs1, i_ID_use_rs2, i_ID_rs1_data, i_ID_rs2_data,
        input  i_ID_imm, i_ID_pc, i_ID_alu_op, i_ID_ctrl_alu_src,
        input  i_ID_ctrl_reg_wr_en, i_ID_ctrl_mem_rd, i_ID_ctrl_mem_wr,
        input  i_flush, i_IM_forward_1, i_IM_forward_2,
        input  i_WB_forward_1, i_WB_forward_2, i_IM_result, i_WB_result,
        output o_IE_valid, o_IE_src_reg_1, o_IE_src_reg_2, o_IE_dst_reg,
        output o_IE_op_a, o_IE_op_b, o_IE_store_data, o_IE_imm, o_IE_pc,
        output o_IE_alu_op, o_IE_ctrl_reg_wr_en, o_IE_ctrl_mem_rd,
        output o_IE_ctrl_mem_wr, o_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes,
// load-use stall detection and branch flush.
module id_ex_stage (
    input logic i_clk,
    input logic i_reset_n,
    id_ex_if.slave bus
);
    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [4:0]      src1;
        logic [4:0]      src2;
        logic [4:0]      dst;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            reg_wr_en;
        logic            mem_rd;
        logic            mem_wr;
    } ie_t;

    ie_t ie_q, ie_d;
    logic hazard;
    logic hit1, hit2;
    logic [XLEN-1:0] fwd1, fwd2;

    assign hit1 = bus.i_ID_use_rs1 && (bus.i_ID_src_reg_1 == ie_q.dst);
    assign hit2 = bus.i_ID_use_rs2 && (bus.i_ID_src_reg_2 == ie_q.dst);

    // A load into x0 never produces a value worth waiting for
    assign hazard = ie_q.valid && ie_q.mem_rd && (ie_q.dst != 5'd0) &&
                    bus.i_ID_valid && (hit1 || hit2);

    assign bus.o_stall = hazard && !bus.i_flush;

    always_comb begin
        ie_d.valid     = bus.i_ID_valid;
        ie_d.src1      = bus.i_ID_src_reg_1;
        ie_d.src2      = bus.i_ID_src_reg_2;
        ie_d.dst       = bus.i_ID_dst_reg;
        ie_d.rs1_data  = bus.i_ID_rs1_data;
        ie_d.rs2_data  = bus.i_ID_rs2_data;
        ie_d.imm       = bus.i_ID_imm;
        ie_d.pc        = bus.i_ID_pc;
        ie_d.alu_op    = bus.i_ID_alu_op;
        ie_d.alu_src   = bus.i_ID_ctrl_alu_src;
        ie_d.reg_wr_en = bus.i_ID_ctrl_reg_wr_en;
        ie_d.mem_rd    = bus.i_ID_ctrl_mem_rd;
        ie_d.mem_wr    = bus.i_ID_ctrl_mem_wr;
        // Bubble kills control and indices; data may stay stale
        if (bus.i_flush || hazard) begin
            ie_d.valid     = 1'b0;
            ie_d.src1      = 5'd0;
            ie_d.src2      = 5'd0;
            ie_d.dst       = 5'd0;
            ie_d.reg_wr_en = 1'b0;
            ie_d.mem_rd    = 1'b0;
            ie_d.mem_wr    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ie_q <= '0;
        end else begin
            ie_q <= ie_d;
        end
    end

    always_comb begin
        fwd1 = ie_q.rs1_data;
        fwd2 = ie_q.rs2_data;
        if (ie_q.valid) begin
            if (bus.i_IM_forward_1) fwd1 = bus.i_IM_result;
            else if (bus.i_WB_forward_1) fwd1 = bus.i_WB_result;
            if (bus.i_IM_forward_2) fwd2 = bus.i_IM_result;
            else if (bus.i_WB_forward_2) fwd2 = bus.i_WB_result;
        end
    end

    assign bus.o_IE_valid          = ie_q.valid;
    assign bus.o_IE_src_reg_1      = ie_q.src1;
    assign bus.o_IE_src_reg_2      = ie_q.src2;
    assign bus.o_IE_dst_reg        = ie_q.dst;
    assign bus.o_IE_op_a           = fwd1;
    assign bus.o_IE_op_b           = ie_q.alu_src ? ie_q.imm : fwd2;
    assign bus.o_IE_store_data     = fwd2;
    assign bus.o_IE_imm            = ie_q.imm;
    assign bus.o_IE_pc             = ie_q.pc;
    assign bus.o_IE_alu_op         = ie_q.alu_op;
    assign bus.o_IE_ctrl_reg_wr_en = ie_q.reg_wr_en && ie_q.valid;
    assign bus.o_IE_ctrl_mem_rd    = ie_q.mem_rd && ie_q.valid;
    assign bus.o_IE_ctrl_mem_wr    = ie_q.mem_wr && ie_q.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: capture, forwarding,
// load-use stall, flush and async reset.
module tb_id_ex_stage;
    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;

    id_ex_if bus ();

    id_ex_stage dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        logic [31:0] d1, d2, imm, pc;
        logic [3:0]  op;
        logic        alusrc, wr, mrd, mwr;
        logic        im1, wb1, im2, wb2;
        logic [31:0] imres, wbres;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [31:0] e_a, e_b, e_sd;
        logic        e_wr, e_mrd, e_mwr;
    } vec_t;

    localparam int NV = 7;
    vec_t vt[NV];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        bus.i_ID_valid = 0; bus.i_ID_src_reg_1 = 0; bus.i_ID_src_reg_2 = 0;
        bus.i_ID_dst_reg = 0; bus.i_ID_use_rs1 = 0; bus.i_ID_use_rs2 = 0;
        bus.i_ID_rs1_data = 0; bus.i_ID_rs2_data = 0; bus.i_ID_imm = 0;
        bus.i_ID_pc = 0; bus.i_ID_alu_op = 0; bus.i_ID_ctrl_alu_src = 0;
        bus.i_ID_ctrl_reg_wr_en = 0; bus.i_ID_ctrl_mem_rd = 0;
        bus.i_ID_ctrl_mem_wr = 0; bus.i_flush = 0;
        bus.i_IM_forward_1 = 0; bus.i_IM_forward_2 = 0;
        bus.i_WB_forward_1 = 0; bus.i_WB_forward_2 = 0;
        bus.i_IM_result = 0; bus.i_WB_result = 0;
    endtask

    task automatic drive_id(input vec_t v);
        bus.i_ID_valid = v.valid;
        bus.i_ID_src_reg_1 = v.rs1; bus.i_ID_src_reg_2 = v.rs2;
        bus.i_ID_dst_reg = v.rd;
        bus.i_ID_use_rs1 = v.use1; bus.i_ID_use_rs2 = v.use2;
        bus.i_ID_rs1_data = v.d1; bus.i_ID_rs2_data = v.d2;
        bus.i_ID_imm = v.imm; bus.i_ID_pc = v.pc; bus.i_ID_alu_op = v.op;
        bus.i_ID_ctrl_alu_src = v.alusrc;
        bus.i_ID_ctrl_reg_wr_en = v.wr;
        bus.i_ID_ctrl_mem_rd = v.mrd; bus.i_ID_ctrl_mem_wr = v.mwr;
        bus.i_flush = 0;
        bus.i_IM_forward_1 = 0; bus.i_IM_forward_2 = 0;
        bus.i_WB_forward_1 = 0; bus.i_WB_forward_2 = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(bus.o_IE_valid), 0);
        chk({tag, " rd"}, 32'(bus.o_IE_dst_reg), 0);
        chk({tag, " src1"}, 32'(bus.o_IE_src_reg_1), 0);
        chk({tag, " src2"}, 32'(bus.o_IE_src_reg_2), 0);
        chk({tag, " op_a"}, bus.o_IE_op_a, 0);
        chk({tag, " op_b"}, bus.o_IE_op_b, 0);
        chk({tag, " sd"}, bus.o_IE_store_data, 0);
        chk({tag, " imm"}, bus.o_IE_imm, 0);
        chk({tag, " pc"}, bus.o_IE_pc, 0);
        chk({tag, " aluop"}, 32'(bus.o_IE_alu_op), 0);
        chk({tag, " wr"}, 32'(bus.o_IE_ctrl_reg_wr_en), 0);
        chk({tag, " mrd"}, 32'(bus.o_IE_ctrl_mem_rd), 0);
        chk({tag, " mwr"}, 32'(bus.o_IE_ctrl_mem_wr), 0);
        chk({tag, " stall"}, 32'(bus.o_stall), 0);
    endtask

    vec_t h;

    initial begin
        for (int i = 0; i < NV; i++) vt[i] = '{default: 0};
        // ADD x3, x5, x6
        vt[0].valid = 1; vt[0].rs1 = 5; vt[0].rs2 = 6; vt[0].rd = 3;
        vt[0].use1 = 1; vt[0].use2 = 1; vt[0].d1 = 32'h10; vt[0].d2 = 32'h20;
        vt[0].pc = 32'h100; vt[0].wr = 1;
        vt[0].e_valid = 1; vt[0].e_rd = 3; vt[0].e_a = 32'h10;
        vt[0].e_b = 32'h20; vt[0].e_sd = 32'h20; vt[0].e_wr = 1;
        // IM and WB both on operand 1: IM wins
        vt[1].valid = 1; vt[1].rs1 = 1; vt[1].rs2 = 2; vt[1].rd = 4;
        vt[1].use1 = 1; vt[1].use2 = 1; vt[1].d1 = 32'h111;
        vt[1].d2 = 32'h222; vt[1].pc = 32'h104; vt[1].op = 1; vt[1].wr = 1;
        vt[1].im1 = 1; vt[1].wb1 = 1;
        vt[1].imres = 32'hAAAA; vt[1].wbres = 32'hBBBB;
        vt[1].e_valid = 1; vt[1].e_rd = 4; vt[1].e_a = 32'hAAAA;
        vt[1].e_b = 32'h222; vt[1].e_sd = 32'h222; vt[1].e_wr = 1;
        // WB on operand 2 with immediate operand B
        vt[2].valid = 1; vt[2].rs1 = 9; vt[2].rs2 = 10; vt[2].rd = 11;
        vt[2].use1 = 1; vt[2].use2 = 1; vt[2].d1 = 32'h333;
        vt[2].d2 = 32'h444; vt[2].imm = 32'h4; vt[2].alusrc = 1;
        vt[2].pc = 32'h108; vt[2].op = 2; vt[2].wr = 1;
        vt[2].wb2 = 1; vt[2].imres = 32'hCCCC; vt[2].wbres = 32'hBBBB;
        vt[2].e_valid = 1; vt[2].e_rd = 11; vt[2].e_a = 32'h333;
        vt[2].e_b = 32'h4; vt[2].e_sd = 32'hBBBB; vt[2].e_wr = 1;
        // WB on op 1, IM beats WB on op 2
        vt[3].valid = 1; vt[3].rs1 = 13; vt[3].rs2 = 14; vt[3].rd = 12;
        vt[3].d1 = 32'h5; vt[3].d2 = 32'h6; vt[3].pc = 32'h10c;
        vt[3].op = 3; vt[3].wr = 1;
        vt[3].wb1 = 1; vt[3].im2 = 1; vt[3].wb2 = 1;
        vt[3].imres = 32'h1234; vt[3].wbres = 32'h5678;
        vt[3].e_valid = 1; vt[3].e_rd = 12; vt[3].e_a = 32'h5678;
        vt[3].e_b = 32'h1234; vt[3].e_sd = 32'h1234; vt[3].e_wr = 1;
        // invalid slot: ctrl gated, forwards ignored
        vt[4].valid = 0; vt[4].rd = 13; vt[4].d1 = 32'h77;
        vt[4].d2 = 32'h88; vt[4].pc = 32'h110; vt[4].wr = 1; vt[4].mrd = 1;
        vt[4].im1 = 1; vt[4].im2 = 1; vt[4].imres = 32'hDEAD;
        vt[4].e_valid = 0; vt[4].e_rd = 13; vt[4].e_a = 32'h77;
        vt[4].e_b = 32'h88; vt[4].e_sd = 32'h88;
        // store with forwarded data
        vt[5].valid = 1; vt[5].rs1 = 2; vt[5].rs2 = 3; vt[5].use1 = 1;
        vt[5].use2 = 1; vt[5].d1 = 32'h1000; vt[5].d2 = 32'h55;
        vt[5].imm = 32'h8; vt[5].alusrc = 1; vt[5].mwr = 1;
        vt[5].pc = 32'h114; vt[5].wb2 = 1; vt[5].wbres = 32'h99;
        vt[5].e_valid = 1; vt[5].e_a = 32'h1000; vt[5].e_b = 32'h8;
        vt[5].e_sd = 32'h99; vt[5].e_mwr = 1;
        // lw x7, 16(x2)
        vt[6].valid = 1; vt[6].rs1 = 2; vt[6].use1 = 1; vt[6].rd = 7;
        vt[6].d1 = 32'h2000; vt[6].imm = 32'h10; vt[6].alusrc = 1;
        vt[6].pc = 32'h118; vt[6].op = 0; vt[6].wr = 1; vt[6].mrd = 1;
        vt[6].e_valid = 1; vt[6].e_rd = 7; vt[6].e_a = 32'h2000;
        vt[6].e_b = 32'h10; vt[6].e_sd = 32'h0; vt[6].e_wr = 1;
        vt[6].e_mrd = 1;

        clr_in();
        bus.i_ID_valid = 1; bus.i_ID_rs1_data = 32'h5A5A;
        bus.i_IM_forward_1 = 1; bus.i_IM_result = 32'h9999;
        #3;
        chk_zero("reset");
        @(negedge i_clk);
        i_reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge i_clk);
            drive_id(vt[i]);
            @(posedge i_clk);
            #1;
            bus.i_IM_forward_1 = vt[i].im1; bus.i_WB_forward_1 = vt[i].wb1;
            bus.i_IM_forward_2 = vt[i].im2; bus.i_WB_forward_2 = vt[i].wb2;
            bus.i_IM_result = vt[i].imres; bus.i_WB_result = vt[i].wbres;
            #1;
            chk($sformatf("v%0d valid", i), 32'(bus.o_IE_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d rd", i), 32'(bus.o_IE_dst_reg), 32'(vt[i].e_rd));
            chk($sformatf("v%0d src1", i), 32'(bus.o_IE_src_reg_1), 32'(vt[i].rs1));
            chk($sformatf("v%0d op_a", i), bus.o_IE_op_a, vt[i].e_a);
            chk($sformatf("v%0d op_b", i), bus.o_IE_op_b, vt[i].e_b);
            chk($sformatf("v%0d sd", i), bus.o_IE_store_data, vt[i].e_sd);
            chk($sformatf("v%0d pc", i), bus.o_IE_pc, vt[i].pc);
            chk($sformatf("v%0d aluop", i), 32'(bus.o_IE_alu_op), 32'(vt[i].op));
            chk($sformatf("v%0d wr", i), 32'(bus.o_IE_ctrl_reg_wr_en), 32'(vt[i].e_wr));
            chk($sformatf("v%0d mrd", i), 32'(bus.o_IE_ctrl_mem_rd), 32'(vt[i].e_mrd));
            chk($sformatf("v%0d mwr", i), 32'(bus.o_IE_ctrl_mem_wr), 32'(vt[i].e_mwr));
            chk($sformatf("v%0d stall", i), 32'(bus.o_stall), 0);
        end

        // load-use: IE holds lw x7, decode add x8, x7, x1
        @(negedge i_clk);
        h = '{default: 0};
        h.valid = 1; h.rs1 = 7; h.rs2 = 1; h.rd = 8; h.use1 = 1; h.use2 = 1;
        h.d1 = 32'h5; h.d2 = 32'h6; h.pc = 32'h11c; h.wr = 1;
        drive_id(h);
        #1;
        chk("lu stall", 32'(bus.o_stall), 1);
        @(posedge i_clk);
        #1;
        chk("lu bubble valid", 32'(bus.o_IE_valid), 0);
        chk("lu bubble wr", 32'(bus.o_IE_ctrl_reg_wr_en), 0);
        chk("lu bubble rd", 32'(bus.o_IE_dst_reg), 0);
        chk("lu stall drop", 32'(bus.o_stall), 0);
        @(posedge i_clk);
        #1;
        bus.i_IM_forward_1 = 1; bus.i_IM_result = 32'h777;
        #1;
        chk("lu add valid", 32'(bus.o_IE_valid), 1);
        chk("lu add rd", 32'(bus.o_IE_dst_reg), 8);
        chk("lu add op_a", bus.o_IE_op_a, 32'h777);
        chk("lu add pc", bus.o_IE_pc, 32'h11c);

        // lw x0 then decode reads x0: no stall
        @(negedge i_clk);
        h = '{default: 0};
        h.valid = 1; h.rs1 = 1; h.use1 = 1; h.rd = 0; h.wr = 1; h.mrd = 1;
        drive_id(h);
        @(negedge i_clk);
        h = '{default: 0};
        h.valid = 1; h.use1 = 1; h.use2 = 1; h.rd = 5; h.wr = 1;
        drive_id(h);
        #1;
        chk("x0 stall", 32'(bus.o_stall), 0);
        // lw x7, then decode with rs2 field 7 but not used
        @(negedge i_clk);
        h = '{default: 0};
        h.valid = 1; h.rd = 7; h.wr = 1; h.mrd = 1;
        drive_id(h);
        @(negedge i_clk);
        h = '{default: 0};
        h.valid = 1; h.rs1 = 1; h.rs2 = 7; h.use1 = 1; h.rd = 9;
        h.wr = 1; h.mwr = 1;
        drive_id(h);
        #1;
        chk("nouse2 stall", 32'(bus.o_stall), 0);
        bus.i_ID_use_rs2 = 1;
        #1;
        chk("use2 stall", 32'(bus.o_stall), 1);
        bus.i_flush = 1;
        #1;
        chk("flush stall", 32'(bus.o_stall), 0);
        @(posedge i_clk);
        #1;
        chk("flush valid", 32'(bus.o_IE_valid), 0);
        chk("flush wr", 32'(bus.o_IE_ctrl_reg_wr_en), 0);
        chk("flush mrd", 32'(bus.o_IE_ctrl_mem_rd), 0);
        chk("flush mwr", 32'(bus.o_IE_ctrl_mem_wr), 0);
        chk("flush rd", 32'(bus.o_IE_dst_reg), 0);

        // async reset mid-cycle with a live instruction
        @(negedge i_clk);
        h = '{default: 0};
        h.valid = 1; h.rs1 = 3; h.rd = 9; h.use1 = 1; h.d1 = 32'hABC;
        h.imm = 32'h44; h.pc = 32'h200; h.op = 5; h.wr = 1; h.mrd = 1;
        drive_id(h);
        @(posedge i_clk);
        #1;
        chk("pre-rst valid", 32'(bus.o_IE_valid), 1);
        #2;
        i_reset_n = 1'b0;
        bus.i_IM_forward_1 = 1; bus.i_IM_result = 32'h55;
        #1;
        chk_zero("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
